// File: rtl/pipeline_defs.sv
// Shared definitions for the memory/write-back pipeline slice.
// - MC_* : bit positions inside the one-hot mem_control field
// - wb_state_e : encoding of the write-back stage FSM
// - is_misaligned() : address alignment check for halfword/word loads
package pipeline_defs;

  localparam int MC_LB  = 0;
  localparam int MC_LBU = 1;
  localparam int MC_LH  = 2;
  localparam int MC_LHU = 3;
  localparam int MC_LW  = 4;
  localparam int MC_SB  = 5;
  localparam int MC_SH  = 6;
  localparam int MC_SW  = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  // load_ctrl is the load half of mem_control (bits MC_LB..MC_LW).
  function automatic logic is_misaligned(input logic [4:0] load_ctrl,
                                         input logic [1:0] addr);
    logic half_bad;
    logic word_bad;
    half_bad = (load_ctrl[MC_LH] | load_ctrl[MC_LHU]) & addr[0];
    word_bad = load_ctrl[MC_LW] & (addr != 2'b00);
    return half_bad | word_bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction.
// Selects the byte/halfword addressed by addr (little-endian) out of the
// read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  data word returned by memory
//   addr      in  2   low address bits of the load
//   load_ctrl in  5   one-hot load kind: [0]lb [1]lbu [2]lh [3]lhu [4]lw
//   value     out 32  extended load result
module load_extract
  import pipeline_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_ctrl,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection.
  always_comb begin
    byte_s = rdata[7:0];
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Sign/zero extension by load kind; anything else passes the word through.
  always_comb begin
    value = rdata;
    if (load_ctrl[MC_LB]) begin
      value = {{24{byte_s[7]}}, byte_s};
    end else if (load_ctrl[MC_LBU]) begin
      value = {24'h000000, byte_s};
    end else if (load_ctrl[MC_LH]) begin
      value = {{16{half_s[15]}}, half_s};
    end else if (load_ctrl[MC_LHU]) begin
      value = {16'h0000, half_s};
    end else begin
      value = rdata;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-response / write-back stage.
// Retires instructions from EXE/MEM: ALU results are written back the cycle
// after acceptance; loads wait (bounded by TIMEOUT) for a memory response,
// are extracted/extended and then written back. Misaligned loads raise adel,
// timed-out loads raise bus_err. All outputs are registered.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready, in_pc, in_alu_res, in_rn, in_write_regfile,
//   in_mem_to_regfile, in_mem_control : upstream instruction
//   dmem_data_ok, dmem_rdata          : data-memory read response
//   waddr, wdata, wb_write_regfile, wb_pc : register-file write port
//   mem_reg, mem_write_regfile, mem_mem_to_regfile : hazard info to decode
//   adel, bus_err                     : exception pulses
module mem_wb_stage
  import pipeline_defs::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_res,
  input  logic [4:0]  in_rn,
  input  logic        in_write_regfile,
  input  logic        in_mem_to_regfile,
  input  logic [7:0]  in_mem_control,
  input  logic        dmem_data_ok,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        wb_write_regfile,
  output logic [31:0] wb_pc,
  output logic [4:0]  mem_reg,
  output logic        mem_write_regfile,
  output logic        mem_mem_to_regfile,
  output logic        adel,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  wb_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [4:0]       rn_r, rn_s;
  logic [31:0]      pc_r, pc_s;
  logic [1:0]       addr_lo_r, addr_lo_s;
  logic [4:0]       ld_ctrl_r, ld_ctrl_s;
  logic             wr_r, wr_s;

  logic             in_ready_r, in_ready_s;
  logic [4:0]       waddr_r, waddr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic             wb_we_r, wb_we_s;
  logic [31:0]      wb_pc_r, wb_pc_s;
  logic [4:0]       mem_reg_r, mem_reg_s;
  logic             mem_we_r, mem_we_s;
  logic             mem_m2r_r, mem_m2r_s;
  logic             adel_r, adel_s;
  logic             bus_err_r, bus_err_s;

  logic             accept_s;
  logic             is_load_s;
  logic [31:0]      ext_s;

  load_extract u_load_extract (
    .rdata     (dmem_rdata),
    .addr      (addr_lo_r),
    .load_ctrl (ld_ctrl_r),
    .value     (ext_s)
  );

  // in_ready_r is only ever 1 while IDLE, so this also qualifies the state.
  assign accept_s  = in_valid & in_ready_r;
  // A load only needs a WAIT slot if it actually writes; a store flag wins.
  assign is_load_s = in_mem_to_regfile & in_write_regfile & ~(|in_mem_control[7:5]);
  assign cnt_inc_s = cnt_r + CNT_ONE_C;

  // Next-state and next-output logic for the IDLE/WAIT controller.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rn_s       = rn_r;
    pc_s       = pc_r;
    addr_lo_s  = addr_lo_r;
    ld_ctrl_s  = ld_ctrl_r;
    wr_s       = wr_r;
    in_ready_s = 1'b1;
    waddr_s    = waddr_r;
    wdata_s    = wdata_r;
    wb_pc_s    = wb_pc_r;
    wb_we_s    = 1'b0;
    mem_reg_s  = 5'd0;
    mem_we_s   = 1'b0;
    mem_m2r_s  = 1'b0;
    adel_s     = 1'b0;
    bus_err_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_load_s) begin
          rn_s      = in_rn;
          pc_s      = in_pc;
          addr_lo_s = in_alu_res[1:0];
          ld_ctrl_s = in_mem_control[4:0];
          wr_s      = in_write_regfile;
          cnt_s     = '0;
          if (is_misaligned(in_mem_control[4:0], in_alu_res[1:0])) begin
            adel_s = 1'b1;
          end else begin
            state_s    = ST_WAIT;
            in_ready_s = 1'b0;
            mem_reg_s  = in_rn;
            mem_we_s   = in_write_regfile;
            mem_m2r_s  = 1'b1;
          end
        end else if (accept_s) begin
          waddr_s   = in_rn;
          wdata_s   = in_alu_res;
          wb_pc_s   = in_pc;
          wb_we_s   = in_write_regfile & (in_rn != 5'd0);
          mem_reg_s = wb_we_s ? in_rn : 5'd0;
          mem_we_s  = wb_we_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Data arriving on the final counted cycle still takes priority.
        if (dmem_data_ok) begin
          state_s   = ST_IDLE;
          waddr_s   = rn_r;
          wdata_s   = ext_s;
          wb_pc_s   = pc_r;
          wb_we_s   = wr_r & (rn_r != 5'd0);
          mem_reg_s = wb_we_s ? rn_r : 5'd0;
          mem_we_s  = wb_we_s;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_s   = ST_IDLE;
          bus_err_s = 1'b1;
        end else begin
          cnt_s      = cnt_inc_s;
          in_ready_s = 1'b0;
          mem_reg_s  = rn_r;
          mem_we_s   = wr_r;
          mem_m2r_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      rn_r       <= 5'd0;
      pc_r       <= 32'd0;
      addr_lo_r  <= 2'd0;
      ld_ctrl_r  <= 5'd0;
      wr_r       <= 1'b0;
      in_ready_r <= 1'b0;
      waddr_r    <= 5'd0;
      wdata_r    <= 32'd0;
      wb_we_r    <= 1'b0;
      wb_pc_r    <= 32'd0;
      mem_reg_r  <= 5'd0;
      mem_we_r   <= 1'b0;
      mem_m2r_r  <= 1'b0;
      adel_r     <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rn_r       <= rn_s;
      pc_r       <= pc_s;
      addr_lo_r  <= addr_lo_s;
      ld_ctrl_r  <= ld_ctrl_s;
      wr_r       <= wr_s;
      in_ready_r <= in_ready_s;
      waddr_r    <= waddr_s;
      wdata_r    <= wdata_s;
      wb_we_r    <= wb_we_s;
      wb_pc_r    <= wb_pc_s;
      mem_reg_r  <= mem_reg_s;
      mem_we_r   <= mem_we_s;
      mem_m2r_r  <= mem_m2r_s;
      adel_r     <= adel_s;
      bus_err_r  <= bus_err_s;
    end
  end

  assign in_ready           = in_ready_r;
  assign waddr              = waddr_r;
  assign wdata              = wdata_r;
  assign wb_write_regfile   = wb_we_r;
  assign wb_pc              = wb_pc_r;
  assign mem_reg            = mem_reg_r;
  assign mem_write_regfile  = mem_we_r;
  assign mem_mem_to_regfile = mem_m2r_r;
  assign adel               = adel_r;
  assign bus_err            = bus_err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (TIMEOUT=4).
module tb_mem_wb_stage;

  localparam int K_WB  = 0;
  localparam int K_ADE = 1;
  localparam int K_BUS = 2;

  typedef struct {
    int          kind;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_res;
  logic [4:0]  in_rn;
  logic        in_write_regfile;
  logic        in_mem_to_regfile;
  logic [7:0]  in_mem_control;
  logic        dmem_data_ok;
  logic [31:0] dmem_rdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_write_regfile;
  logic [31:0] wb_pc;
  logic [4:0]  mem_reg;
  logic        mem_write_regfile;
  logic        mem_mem_to_regfile;
  logic        adel;
  logic        bus_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  mem_wb_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_res(in_alu_res), .in_rn(in_rn),
    .in_write_regfile(in_write_regfile), .in_mem_to_regfile(in_mem_to_regfile),
    .in_mem_control(in_mem_control), .dmem_data_ok(dmem_data_ok),
    .dmem_rdata(dmem_rdata), .waddr(waddr), .wdata(wdata),
    .wb_write_regfile(wb_write_regfile), .wb_pc(wb_pc), .mem_reg(mem_reg),
    .mem_write_regfile(mem_write_regfile), .mem_mem_to_regfile(mem_mem_to_regfile),
    .adel(adel), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] pc);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Present one instruction for one cycle (caller makes sure in_ready is high).
  task automatic op(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rn,
                    input logic wr, input logic m2r, input logic [7:0] mc);
    in_valid = 1'b1; in_pc = pc; in_alu_res = alu; in_rn = rn;
    in_write_regfile = wr; in_mem_to_regfile = m2r; in_mem_control = mc;
    cyc();
    in_valid = 1'b0;
  endtask

  // Drive a read response that the DUT samples on the next edge.
  task automatic respond(input logic [31:0] data);
    dmem_data_ok = 1'b1; dmem_rdata = data;
    cyc();
    dmem_data_ok = 1'b0;
  endtask

  // Monitor: every retirement/exception pulse must match the queue head.
  always @(negedge clk) begin
    if (wb_write_regfile || adel || bus_err) begin
      int   kind;
      exp_t e;
      kind = 3;
      if (wb_write_regfile && !adel && !bus_err) kind = K_WB;
      if (!wb_write_regfile && adel && !bus_err) kind = K_ADE;
      if (!wb_write_regfile && !adel && bus_err) kind = K_BUS;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got kind=%0d waddr=%0d wdata=%h want none",
                 kind, waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (kind != e.kind ||
            (e.kind == K_WB && (waddr !== e.a || wdata !== e.d || wb_pc !== e.pc))) begin
          failures++;
          $display("FAIL event got kind=%0d waddr=%0d wdata=%h pc=%h want kind=%0d waddr=%0d wdata=%h pc=%h",
                   kind, waddr, wdata, wb_pc, e.kind, e.a, e.d, e.pc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_alu_res = 32'd0; in_rn = 5'd0;
    in_write_regfile = 1'b0; in_mem_to_regfile = 1'b0; in_mem_control = 8'd0;
    dmem_data_ok = 1'b0; dmem_rdata = 32'd0;
    cyc(); cyc();
    chk("reset_outputs", {in_ready, waddr, wdata, wb_write_regfile, mem_reg,
        mem_write_regfile, mem_mem_to_regfile, adel, bus_err}, 64'd0);
    reset = 1'b1;
    cyc();
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Back-to-back ALU ops
    push(K_WB, 5'd5, 32'h1234_5678, 32'h100);
    op(32'h100, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 8'h00);
    chk("hazard_alu", {58'd0, mem_reg, mem_write_regfile}, {58'd0, 5'd5, 1'b1});
    push(K_WB, 5'd6, 32'hAAAA_5555, 32'h104);
    op(32'h104, 32'hAAAA_5555, 5'd6, 1'b1, 1'b0, 8'h00);
    push(K_WB, 5'd7, 32'h0BAD_F00D, 32'h108);
    op(32'h108, 32'h0BAD_F00D, 5'd7, 1'b1, 1'b0, 8'h00);
    cyc(); cyc();

    // rn=0 and store: no write, no WAIT
    op(32'h10C, 32'h5555_0000, 5'd0, 1'b1, 1'b0, 8'h00);
    op(32'h110, 32'h0000_1000, 5'd3, 1'b0, 1'b0, 8'h80);
    chk("store_no_wait", {63'd0, in_ready}, 64'd1);
    cyc();

    // lb, 3 WAIT cycles before data
    push(K_WB, 5'd8, 32'hFFFF_FF80, 32'h200);
    op(32'h200, 32'h0000_1003, 5'd8, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("lb_wait", {57'd0, in_ready, mem_mem_to_regfile, mem_reg},
          {57'd0, 1'b0, 1'b1, 5'd8});
      if (i < 2) cyc();
    end
    respond(32'h80FF_FFFF);
    chk("lb_ready_after", {63'd0, in_ready}, 64'd1);

    // lbu same address
    push(K_WB, 5'd9, 32'h0000_0080, 32'h204);
    op(32'h204, 32'h0000_1003, 5'd9, 1'b1, 1'b1, 8'h02);
    cyc(); cyc();
    respond(32'h80FF_FFFF);

    // lh / lhu / lw aligned
    push(K_WB, 5'd10, 32'hFFFF_8001, 32'h208);
    op(32'h208, 32'h0000_1002, 5'd10, 1'b1, 1'b1, 8'h04);
    respond(32'h8001_0000);
    push(K_WB, 5'd11, 32'h0000_ABCD, 32'h20C);
    op(32'h20C, 32'h0000_1000, 5'd11, 1'b1, 1'b1, 8'h08);
    respond(32'h1234_ABCD);
    push(K_WB, 5'd12, 32'hDEAD_BEEF, 32'h210);
    op(32'h210, 32'h0000_2000, 5'd12, 1'b1, 1'b1, 8'h10);
    respond(32'hDEAD_BEEF);

    // Misaligned lh / lw
    push(K_ADE, 5'd0, 32'd0, 32'd0);
    op(32'h214, 32'h0000_1001, 5'd13, 1'b1, 1'b1, 8'h04);
    chk("adel_stay_idle", {62'd0, in_ready, mem_mem_to_regfile}, {62'd0, 1'b1, 1'b0});
    push(K_ADE, 5'd0, 32'd0, 32'd0);
    op(32'h218, 32'h0000_1002, 5'd14, 1'b1, 1'b1, 8'h10);
    cyc();

    // lw timeout: 4 WAIT cycles, then bus_err
    push(K_BUS, 5'd0, 32'd0, 32'd0);
    op(32'h21C, 32'h0000_3000, 5'd15, 1'b1, 1'b1, 8'h10);
    cyc(); cyc(); cyc();
    chk("timeout_still_wait", {63'd0, in_ready}, 64'd1 - 64'd1);
    cyc();
    chk("timeout_ready", {63'd0, in_ready}, 64'd1);

    // Data on the 4th WAIT cycle wins over timeout
    push(K_WB, 5'd16, 32'hCAFE_0001, 32'h220);
    op(32'h220, 32'h0000_3004, 5'd16, 1'b1, 1'b1, 8'h10);
    cyc(); cyc(); cyc();
    respond(32'hCAFE_0001);

    // data_ok in IDLE is ignored
    respond(32'h1111_1111);
    cyc();

    // Reset mid-WAIT discards the load
    op(32'h224, 32'h0000_4000, 5'd17, 1'b1, 1'b1, 8'h10);
    cyc();
    reset = 1'b0;
    cyc();
    chk("reset_mid_wait", {in_ready, waddr, wdata, wb_write_regfile, mem_reg,
        mem_write_regfile, mem_mem_to_regfile, adel, bus_err}, 64'd0);
    chk("reset_wb_pc", {32'd0, wb_pc}, 64'd0);
    reset = 1'b1;
    cyc();
    respond(32'h2222_2222);
    cyc(); cyc(); cyc();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
